// File: rtl/uart_rx_oversampled_pkg.sv
// Shared UART definitions: receiver state encoding and elaboration-time
// sizing helpers. Intended for reuse by a future uart_tx.
package uart_rx_oversampled_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP,
    ST_BREAK
  } uart_state_t;

  // Clock cycles per oversample tick, truncated.
  function automatic int unsigned uart_div(input int unsigned clk_rate,
                                           input int unsigned baud_rate,
                                           input int unsigned oversample);
    return clk_rate / (baud_rate * oversample);
  endfunction

  // Width of a counter that runs 0..n-1, never less than 1 bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/uart_rx_oversampled_os_tick.sv
// Oversample tick generator: free-running 0..DIV-1 counter with a
// synchronous restart, os_tick is high for one clk at DIV-1.
module uart_os_tick
  import uart_rx_oversampled_pkg::*;
#(
  parameter int unsigned DIV = 6
) (
  input  logic clk,
  input  logic rst,
  input  logic restart,
  output logic os_tick
);

  localparam int unsigned CW = cnt_width(DIV);
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt;

  // Divider counter; restart realigns the tick phase to the start edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (restart || cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign os_tick = (cnt == LAST);

endmodule

// File: rtl/uart_rx_oversampled.sv
// Oversampled UART receiver with mid-bit sampling, framing/parity checks
// and a valid/ready output holding register with sticky overrun.
// Optional parity stage: define UART_RX_PARITY_EN.
module uart_rx_oversampled
  import uart_rx_oversampled_pkg::*;
#(
  parameter int unsigned CLK_RATE   = 12000000,
  parameter int unsigned BAUD_RATE  = 125000,
  parameter int unsigned OVERSAMPLE = 16,
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned STOP_BITS  = 1,
  parameter int unsigned PARITY_ODD = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 valid,
  input  logic                 ready,
  output logic                 frame_err,
  output logic                 parity_err,
  output logic                 overrun,
  output logic                 busy
);

  localparam int unsigned DIV = uart_div(CLK_RATE, BAUD_RATE, OVERSAMPLE);
  localparam int unsigned TW  = cnt_width(OVERSAMPLE);
  localparam int unsigned BW  = cnt_width(DATA_BITS);
  localparam logic [TW-1:0] HALF_LAST = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] FULL_LAST = TW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] DATA_LAST = BW'(DATA_BITS - 1);
  localparam logic [BW-1:0] STOP_LAST = BW'(STOP_BITS - 1);

  if (DIV < 1) begin : g_div_chk
    $error("uart_rx_oversampled: CLK_RATE too low for BAUD_RATE*OVERSAMPLE");
  end
  if (OVERSAMPLE < 4 || (OVERSAMPLE % 2) != 0) begin : g_os_chk
    $error("uart_rx_oversampled: OVERSAMPLE must be even and >= 4");
  end
  if (DATA_BITS < 5 || DATA_BITS > 16) begin : g_db_chk
    $error("uart_rx_oversampled: DATA_BITS must be 5..16");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2 || PARITY_ODD > 1) begin : g_sb_chk
    $error("uart_rx_oversampled: STOP_BITS must be 1..2, PARITY_ODD 0..1");
  end

  uart_state_t          state, state_next;
  logic                 rx_meta, rx_s;
  logic                 os_tick, restart;
  logic [TW-1:0]        tick_cnt;
  logic [BW-1:0]        bit_cnt;
  logic [DATA_BITS-1:0] shreg;
  logic                 stop_bad;
  logic                 samp, commit, commit_pend;
  logic                 par_calc;

  assign restart = (state == ST_IDLE) && !rx_s;
  assign busy    = (state != ST_IDLE);

  uart_os_tick #(.DIV(DIV)) u_tick (
    .clk     (clk),
    .rst     (rst),
    .restart (restart),
    .os_tick (os_tick)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_next;
  end

  // Next-state logic and per-bit sample/commit strobes.
  always_comb begin
    state_next = state;
    samp       = 1'b0;
    commit     = 1'b0;
    case (state)
      ST_IDLE:  if (!rx_s) state_next = ST_START;
      ST_START: if (os_tick && tick_cnt == HALF_LAST) begin
        samp       = 1'b1;
        state_next = rx_s ? ST_IDLE : ST_DATA;
      end
      ST_DATA:  if (os_tick && tick_cnt == FULL_LAST) begin
        samp = 1'b1;
`ifdef UART_RX_PARITY_EN
        if (bit_cnt == DATA_LAST) state_next = ST_PARITY;
`else
        if (bit_cnt == DATA_LAST) state_next = ST_STOP;
`endif
      end
`ifdef UART_RX_PARITY_EN
      ST_PARITY: if (os_tick && tick_cnt == FULL_LAST) begin
        samp       = 1'b1;
        state_next = ST_STOP;
      end
`endif
      ST_STOP:  if (os_tick && tick_cnt == FULL_LAST) begin
        samp = 1'b1;
        if (bit_cnt == STOP_LAST) begin
          commit     = 1'b1;
          state_next = (stop_bad || !rx_s) ? ST_BREAK : ST_IDLE;
        end
      end
      ST_BREAK: if (rx_s) state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  // Synchroniser, tick/bit counters and the receive shift register.
  // Commit is delayed one clk so the final stop sample is folded into stop_bad
  // before the word is loaded, while the FSM is already back in IDLE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_meta     <= 1'b1;
      rx_s        <= 1'b1;
      tick_cnt    <= '0;
      bit_cnt     <= '0;
      shreg       <= '0;
      stop_bad    <= 1'b0;
      commit_pend <= 1'b0;
    end else begin
      rx_meta     <= rx;
      rx_s        <= rx_meta;
      commit_pend <= commit;
      if (state == ST_IDLE)  tick_cnt <= '0;
      else if (os_tick)      tick_cnt <= samp ? '0 : tick_cnt + 1'b1;
      if (state == ST_IDLE) begin
        bit_cnt  <= '0;
        stop_bad <= 1'b0;
      end else if (samp) begin
        bit_cnt <= (state_next != state) ? '0 : bit_cnt + 1'b1;
        if (state == ST_DATA)          shreg    <= {rx_s, shreg[DATA_BITS-1:1]};
        if (state == ST_STOP && !rx_s) stop_bad <= 1'b1;
      end
    end
  end

`ifdef UART_RX_PARITY_EN
  logic par_bit;

  // Captured parity bit of the current frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                               par_bit <= 1'b0;
    else if (samp && state == ST_PARITY)   par_bit <= rx_s;
  end

  assign par_calc = ((^shreg) ^ par_bit) != 1'(PARITY_ODD);
`else
  assign par_calc = 1'b0;
`endif

  // Output holding register: load on commit, drop and flag overrun if full.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_out   <= '0;
      valid      <= 1'b0;
      frame_err  <= 1'b0;
      parity_err <= 1'b0;
      overrun    <= 1'b0;
    end else if (commit_pend) begin
      if (valid && !ready) begin
        overrun <= 1'b1;
      end else begin
        data_out   <= shreg;
        frame_err  <= stop_bad;
        parity_err <= par_calc;
        valid      <= 1'b1;
        overrun    <= 1'b0;
      end
    end else if (valid && ready) begin
      valid   <= 1'b0;
      overrun <= 1'b0;
    end
  end

endmodule

// File: tb/tb_uart_rx_oversampled.sv
// Directed bench for uart_rx_oversampled (DIV=6, 96 clk per bit) with a
// scoreboard queue popped on each valid&&ready handshake.
module tb_uart_rx_oversampled;

  localparam int unsigned BIT = 96;

  logic       clk = 1'b0;
  logic       rst, rx, ready;
  logic [7:0] data_out;
  logic       valid, frame_err, parity_err, overrun, busy;

  typedef struct {
    logic [7:0] d;
    logic       fe;
    logic       pe;
  } exp_t;

  exp_t        q[$];
  exp_t        mon_e;
  int unsigned total = 0;
  int unsigned bad   = 0;
  int unsigned cyc = 0, start_cyc = 0, rise_cyc = 0, vlen = 0;
  logic        v_prev = 1'b0;
  logic        pbit_unused;

  uart_rx_oversampled #(
    .CLK_RATE  (12000000),
    .BAUD_RATE (125000),
    .OVERSAMPLE(16),
    .DATA_BITS (8),
    .STOP_BITS (1),
    .PARITY_ODD(0)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .rx        (rx),
    .data_out  (data_out),
    .valid     (valid),
    .ready     (ready),
    .frame_err (frame_err),
    .parity_err(parity_err),
    .overrun   (overrun),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (valid && !v_prev) begin
      rise_cyc = cyc;
      vlen     = 0;
    end
    if (valid) vlen++;
    v_prev = valid;
  end

  // Scoreboard: every handshake must match the oldest expected word.
  always @(negedge clk) begin
    if (!rst && valid && ready) begin
      total++;
      assert (q.size() != 0) else begin
        bad++;
        $error("FAIL unexpected_valid got=%h want=none", data_out);
      end
      if (q.size() != 0) begin
        mon_e = q.pop_front();
        total++;
        assert (data_out === mon_e.d) else begin
          bad++;
          $error("FAIL data got=%h want=%h", data_out, mon_e.d);
        end
        total++;
        assert (frame_err === mon_e.fe) else begin
          bad++;
          $error("FAIL frame_err got=%b want=%b (data %h)", frame_err, mon_e.fe, mon_e.d);
        end
        total++;
        assert (parity_err === mon_e.pe) else begin
          bad++;
          $error("FAIL parity_err got=%b want=%b (data %h)", parity_err, mon_e.pe, mon_e.d);
        end
      end
    end
  end

  initial begin
    repeat (60000) @(posedge clk);
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] want);
    total++;
    assert (got === want) else begin
      bad++;
      $error("FAIL %s got=%h want=%h", tag, got, want);
    end
  endtask

  task automatic send_bits(input logic lvl, input int unsigned n);
    rx = lvl;
    repeat (n) @(negedge clk);
  endtask

  // Start bit, data LSB first and (when compiled in) the parity bit.
  task automatic send_head(input logic [7:0] d, input logic pflip);
    logic pbit;
    pbit      = (^d) ^ pflip;
    start_cyc = cyc;
    send_bits(1'b0, BIT);
    for (int unsigned i = 0; i < 8; i++) send_bits(d[i], BIT);
`ifdef UART_RX_PARITY_EN
    send_bits(pbit, BIT);
`else
    pbit_unused = pbit;
`endif
  endtask

  task automatic send_frame(input logic [7:0] d, input logic pflip);
    send_head(d, pflip);
    send_bits(1'b1, BIT);
  endtask

  task automatic wait_drain();
    int unsigned n = 0;
    while (q.size() != 0 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk("drain_pending", 16'(q.size()), 16'd0);
  endtask

  initial begin
    int lat;
    rst   = 1'b1;
    rx    = 1'b1;
    ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_valid", 16'(valid), 16'd0);
    chk("rst_busy", 16'(busy), 16'd0);
    chk("rst_data", 16'(data_out), 16'd0);
    chk("rst_flags", {13'd0, frame_err, parity_err, overrun}, 16'd0);
    rst = 1'b0;
    send_bits(1'b1, BIT);

    // 1: basic frame, latency and one-cycle valid with ready held high.
    q.push_back('{8'hA5, 1'b0, 1'b0});
    send_frame(8'hA5, 1'b0);
    wait_drain();
    lat = int'(rise_cyc - start_cyc);
`ifdef UART_RX_PARITY_EN
    lat = lat - int'(BIT);
`endif
    total++;
    assert (lat >= 908 && lat <= 922) else begin
      bad++;
      $error("FAIL t1_latency got=%0d want=908..922", lat);
    end
    chk("t1_valid_len", 16'(vlen), 16'd1);
    send_bits(1'b1, BIT);

    // 2: 40-clk glitch is rejected at the mid-start sample.
    rx = 1'b0;
    repeat (40) @(negedge clk);
    chk("t2_busy_in_glitch", 16'(busy), 16'd1);
    rx = 1'b1;
    for (int unsigned n = 0; n < 50 && busy; n++) @(negedge clk);
    chk("t2_busy_cleared", 16'(busy), 16'd0);
    chk("t2_no_valid", 16'(valid), 16'd0);
    send_bits(1'b1, BIT);
    q.push_back('{8'h5A, 1'b0, 1'b0});
    send_frame(8'h5A, 1'b0);
    wait_drain();
    send_bits(1'b1, BIT);

    // 3: stop held low -> frame error, BREAK until line returns high.
    q.push_back('{8'h00, 1'b1, 1'b0});
    send_head(8'h00, 1'b0);
    send_bits(1'b0, 1000);
    chk("t3_drained", 16'(q.size()), 16'd0);
    chk("t3_busy_break", 16'(busy), 16'd1);
    chk("t3_frame_err_held", 16'(frame_err), 16'd1);
    send_bits(1'b0, 1000);
    send_bits(1'b1, 10);
    chk("t3_idle_after_break", 16'(busy), 16'd0);
    send_bits(1'b1, BIT);
    q.push_back('{8'h81, 1'b0, 1'b0});
    send_frame(8'h81, 1'b0);
    wait_drain();
    send_bits(1'b1, BIT);

    // 4: overrun while the consumer stalls.
    @(posedge clk);
    #1 ready = 1'b0;
    @(negedge clk);
    q.push_back('{8'h11, 1'b0, 1'b0});
    send_frame(8'h11, 1'b0);
    chk("t4_valid_first", 16'(valid), 16'd1);
    chk("t4_overrun_first", 16'(overrun), 16'd0);
    send_frame(8'h22, 1'b0);
    chk("t4_valid_held", 16'(valid), 16'd1);
    chk("t4_data_held", 16'(data_out), 16'h0011);
    chk("t4_overrun_set", 16'(overrun), 16'd1);
    @(posedge clk);
    #1 ready = 1'b1;
    @(posedge clk);
    #1;
    chk("t4_valid_cleared", 16'(valid), 16'd0);
    chk("t4_overrun_cleared", 16'(overrun), 16'd0);
    chk("t4_popped", 16'(q.size()), 16'd0);
    @(negedge clk);
    send_bits(1'b1, BIT);

`ifdef UART_RX_PARITY_EN
    // 5: even parity, correct then corrupted parity bit.
    q.push_back('{8'h07, 1'b0, 1'b0});
    send_frame(8'h07, 1'b0);
    wait_drain();
    send_bits(1'b1, BIT);
    q.push_back('{8'h07, 1'b0, 1'b1});
    send_frame(8'h07, 1'b1);
    wait_drain();
    send_bits(1'b1, BIT);
`endif

    // 6: reset mid-frame discards it; next frame is clean.
    send_bits(1'b0, BIT);
    send_bits(1'b1, 4 * BIT);
    rst = 1'b1;
    #1;
    chk("t6_rst_busy", 16'(busy), 16'd0);
    chk("t6_rst_valid", 16'(valid), 16'd0);
    chk("t6_rst_data", 16'(data_out), 16'd0);
    chk("t6_rst_flags", {13'd0, frame_err, parity_err, overrun}, 16'd0);
    @(negedge clk);
    rst = 1'b0;
    send_bits(1'b1, 5 * BIT);
    chk("t6_no_valid", 16'(valid), 16'd0);
    q.push_back('{8'h3C, 1'b0, 1'b0});
    send_frame(8'h3C, 1'b0);
    wait_drain();
    send_bits(1'b1, BIT);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
